// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: default widths, opcode
// encodings and the driver FSM state type.
package alu_pkg;

  localparam int ALU_WIDTH = 4;
  localparam int ALU_OP_W  = 3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_LT  = 3'd6;
  localparam logic [2:0] OP_EQ  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2
  } drv_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with fall-through head; full/empty derived from
// read/write pointers carrying one extra wrap bit.
module alu_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator for the combinational ALU: buffers commands, drives the ALU
// inputs, captures its outputs and offers them on a result stream.
// Optional carry chaining is enabled by defining ALU_CHAIN_EN.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4,
  parameter int OP_W  = ALU_OP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic             cmd_c,
  input  logic [WIDTH-1:0] cmd_x,
  input  logic [WIDTH-1:0] cmd_y,
  input  logic             cmd_chain,
  output logic [OP_W-1:0]  alu_op,
  output logic             alu_in_c,
  output logic [WIDTH-1:0] alu_in_x,
  output logic [WIDTH-1:0] alu_in_y,
  input  logic [WIDTH-1:0] alu_out_s,
  input  logic             alu_out_c,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_s,
  output logic             res_c,
  output logic             res_zero,
  output logic             res_ovf,
  output logic             busy
);

  localparam int FW = OP_W + 2 + 2 * WIDTH;

  drv_state_e       state_q, state_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic             alu_in_c_q, alu_in_c_d;
  logic [WIDTH-1:0] alu_in_x_q, alu_in_x_d;
  logic [WIDTH-1:0] alu_in_y_q, alu_in_y_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_s_q, res_s_d;
  logic             res_c_q, res_c_d;
  logic             res_zero_q, res_zero_d;
  logic             res_ovf_q, res_ovf_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]    fifo_rd_data;
  logic [OP_W-1:0]  head_op;
  logic             head_c, head_chain, head_carry;
  logic [WIDTH-1:0] head_x, head_y;

  alu_cmd_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data ({cmd_op, cmd_c, cmd_chain, cmd_x, cmd_y}),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full;
  assign {head_op, head_c, head_chain, head_x, head_y} = fifo_rd_data;

`ifdef ALU_CHAIN_EN
  // res_c_q still holds the previous capture when the next command is popped
  assign head_carry = head_chain ? res_c_q : head_c;
`else
  logic unused_chain;
  assign unused_chain = head_chain;
  assign head_carry   = head_c;
`endif

  always_comb begin
    state_d     = state_q;
    alu_op_d    = alu_op_q;
    alu_in_c_d  = alu_in_c_q;
    alu_in_x_d  = alu_in_x_q;
    alu_in_y_d  = alu_in_y_q;
    res_valid_d = res_valid_q;
    res_s_d     = res_s_q;
    res_c_d     = res_c_q;
    res_zero_d  = res_zero_q;
    res_ovf_d   = res_ovf_q;
    fifo_pop    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          alu_op_d   = head_op;
          alu_in_c_d = head_carry;
          alu_in_x_d = head_x;
          alu_in_y_d = head_y;
          state_d    = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        res_s_d     = alu_out_s;
        res_c_d     = alu_out_c;
        res_zero_d  = alu_zero;
        res_ovf_d   = alu_overflow;
        res_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            alu_op_d   = head_op;
            alu_in_c_d = head_carry;
            alu_in_x_d = head_x;
            alu_in_y_d = head_y;
            state_d    = ST_DRIVE;
          end else begin
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      alu_op_q    <= '0;
      alu_in_c_q  <= 1'b0;
      alu_in_x_q  <= '0;
      alu_in_y_q  <= '0;
      res_valid_q <= 1'b0;
      res_s_q     <= '0;
      res_c_q     <= 1'b0;
      res_zero_q  <= 1'b0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_op_q    <= alu_op_d;
      alu_in_c_q  <= alu_in_c_d;
      alu_in_x_q  <= alu_in_x_d;
      alu_in_y_q  <= alu_in_y_d;
      res_valid_q <= res_valid_d;
      res_s_q     <= res_s_d;
      res_c_q     <= res_c_d;
      res_zero_q  <= res_zero_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_in_c  = alu_in_c_q;
  assign alu_in_x  = alu_in_x_q;
  assign alu_in_y  = alu_in_y_q;
  assign res_valid = res_valid_q;
  assign res_s     = res_s_q;
  assign res_c     = res_c_q;
  assign res_zero  = res_zero_q;
  assign res_ovf   = res_ovf_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural 4-bit ALU alongside.
// Expected chained-carry results follow ALU_CHAIN_EN.
module tb_alu_cmd_driver;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic       cmd_c = 1'b0;
  logic [3:0] cmd_x = '0;
  logic [3:0] cmd_y = '0;
  logic       cmd_chain = 1'b0;
  logic [2:0] alu_op;
  logic       alu_in_c;
  logic [3:0] alu_in_x, alu_in_y;
  logic [3:0] alu_out_s;
  logic       alu_out_c, alu_zero, alu_overflow;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_s;
  logic       res_c, res_zero, res_ovf, busy;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef ALU_CHAIN_EN
  localparam logic EXP_CHAIN = 1'b1;
`else
  localparam logic EXP_CHAIN = 1'b0;
`endif

  alu_cmd_driver #(.WIDTH(4), .DEPTH(4), .OP_W(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_c(cmd_c),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_chain(cmd_chain),
    .alu_op(alu_op), .alu_in_c(alu_in_c), .alu_in_x(alu_in_x), .alu_in_y(alu_in_y),
    .alu_out_s(alu_out_s), .alu_out_c(alu_out_c), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_ready(res_ready), .res_s(res_s), .res_c(res_c),
    .res_zero(res_zero), .res_ovf(res_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: add/sub with carry/borrow and signed overflow, logic ops, compares
  logic [4:0] alu_t;
  always_comb begin
    alu_t        = '0;
    alu_out_c    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_t        = {1'b0, alu_in_x} + {1'b0, alu_in_y} + {4'b0, alu_in_c};
        alu_out_c    = alu_t[4];
        alu_overflow = (alu_in_x[3] == alu_in_y[3]) && (alu_t[3] != alu_in_x[3]);
      end
      OP_SUB: begin
        alu_t        = {1'b0, alu_in_x} - {1'b0, alu_in_y} - {4'b0, alu_in_c};
        alu_out_c    = alu_t[4];
        alu_overflow = (alu_in_x[3] != alu_in_y[3]) && (alu_t[3] != alu_in_x[3]);
      end
      OP_NOT:  alu_t = {1'b0, ~alu_in_x};
      OP_AND:  alu_t = {1'b0, alu_in_x & alu_in_y};
      OP_OR:   alu_t = {1'b0, alu_in_x | alu_in_y};
      OP_XOR:  alu_t = {1'b0, alu_in_x ^ alu_in_y};
      OP_LT:   alu_t = {4'b0, alu_in_x < alu_in_y};
      default: alu_t = {4'b0, alu_in_x == alu_in_y};
    endcase
  end
  assign alu_out_s = alu_t[3:0];
  assign alu_zero  = (alu_t[3:0] == 4'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [2:0] op, input logic c, input logic [3:0] x,
                         input logic [3:0] y, input logic chain);
    cmd_op = op; cmd_c = c; cmd_x = x; cmd_y = y; cmd_chain = chain;
  endtask

  task automatic send(input logic [2:0] op, input logic c, input logic [3:0] x,
                      input logic [3:0] y, input logic chain);
    set_cmd(op, c, x, y, chain);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    // Reset
    #1 rst = 1'b1;
    #2;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_alu_op",    32'(alu_op),    32'd0);
    chk("rst_res_s",     32'(res_s),     32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1: ADD 3+4, latency
    res_ready = 1'b1;
    send(OP_ADD, 1'b0, 4'd3, 4'd4, 1'b0);
    chk("t1_e0_valid", 32'(res_valid), 32'd0);
    chk("t1_e0_busy",  32'(busy),      32'd1);
    tick();
    chk("t1_e1_valid", 32'(res_valid), 32'd0);
    chk("t1_alu_x",    32'(alu_in_x),  32'd3);
    chk("t1_alu_y",    32'(alu_in_y),  32'd4);
    tick();
    chk("t1_e2_valid", 32'(res_valid), 32'd1);
    chk("t1_s",        32'(res_s),     32'd7);
    chk("t1_c",        32'(res_c),     32'd0);
    chk("t1_zero",     32'(res_zero),  32'd0);
    chk("t1_ovf",      32'(res_ovf),   32'd0);
    tick();
    chk("t1_done_valid", 32'(res_valid), 32'd0);
    chk("t1_done_busy",  32'(busy),      32'd0);

    // 2: back-to-back ADD 7+1 and SUB 4-4
    send(OP_ADD, 1'b0, 4'd7, 4'd1, 1'b0);
    send(OP_SUB, 1'b0, 4'd4, 4'd4, 1'b0);
    chk("t2_e1_valid", 32'(res_valid), 32'd0);
    tick();
    chk("t2_a_valid", 32'(res_valid), 32'd1);
    chk("t2_a_s",     32'(res_s),     32'd8);
    chk("t2_a_ovf",   32'(res_ovf),   32'd1);
    chk("t2_a_zero",  32'(res_zero),  32'd0);
    tick();
    chk("t2_gap_valid", 32'(res_valid), 32'd0);
    chk("t2_b_op",      32'(alu_op),    32'(OP_SUB));
    tick();
    chk("t2_b_valid", 32'(res_valid), 32'd1);
    chk("t2_b_s",     32'(res_s),     32'd0);
    chk("t2_b_zero",  32'(res_zero),  32'd1);
    chk("t2_b_ovf",   32'(res_ovf),   32'd0);
    tick();
    chk("t2_done_busy", 32'(busy), 32'd0);

    // 3: backpressure, capacity DEPTH+1
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_cmd(OP_ADD, 1'b0, 4'(k), 4'd1, 1'b0);
      chk($sformatf("t3_ready_%0d", k), 32'(cmd_ready), (k < 5) ? 32'd1 : 32'd0);
      tick();
    end
    cmd_valid = 1'b0;
    chk("t3_full_ready", 32'(cmd_ready), 32'd0);
    chk("t3_hold_valid", 32'(res_valid), 32'd1);
    chk("t3_hold_s0",    32'(res_s),     32'd1);
    tick();
    tick();
    chk("t3_stable_s",     32'(res_s),     32'd1);
    chk("t3_stable_valid", 32'(res_valid), 32'd1);
    chk("t3_stable_ready", 32'(cmd_ready), 32'd0);
    res_ready = 1'b1;
    tick();
    chk("t3_ready_back", 32'(cmd_ready), 32'd1);
    chk("t3_drop_valid", 32'(res_valid), 32'd0);
    for (int k = 1; k < 5; k++) begin
      tick();
      chk($sformatf("t3_r%0d_valid", k), 32'(res_valid), 32'd1);
      chk($sformatf("t3_r%0d_s", k),     32'(res_s),     32'(k + 1));
      tick();
      chk($sformatf("t3_r%0d_gap", k),   32'(res_valid), 32'd0);
    end
    chk("t3_done_busy", 32'(busy), 32'd0);

    // 4: carry chaining
    send(OP_ADD, 1'b0, 4'hF, 4'h1, 1'b0);
    tick();
    tick();
    chk("t4_a_s", 32'(res_s), 32'd0);
    chk("t4_a_c", 32'(res_c), 32'd1);
    tick();
    send(OP_ADD, 1'b0, 4'd0, 4'd0, 1'b1);
    tick();
    chk("t4_b_in_c", 32'(alu_in_c), 32'(EXP_CHAIN));
    tick();
    chk("t4_b_s", 32'(res_s), 32'(EXP_CHAIN));
    tick();

    // 5: reset while HOLD with 3 queued
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_cmd(OP_XOR, 1'b0, 4'(k + 5), 4'd3, 1'b0);
      tick();
    end
    cmd_valid = 1'b0;
    chk("t5_pre_valid", 32'(res_valid), 32'd1);
    chk("t5_pre_s",     32'(res_s),     32'd6);
    chk("t5_pre_op",    32'(alu_op),    32'(OP_XOR));
    rst = 1'b1;
    #2;
    chk("t5_rst_valid", 32'(res_valid), 32'd0);
    chk("t5_rst_op",    32'(alu_op),    32'd0);
    chk("t5_rst_x",     32'(alu_in_x),  32'd0);
    chk("t5_rst_s",     32'(res_s),     32'd0);
    chk("t5_rst_busy",  32'(busy),      32'd0);
    chk("t5_rst_ready", 32'(cmd_ready), 32'd1);
    tick();
    rst = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t5_post%0d_valid", k), 32'(res_valid), 32'd0);
      chk($sformatf("t5_post%0d_busy", k),  32'(busy),      32'd0);
    end

    // 6: push and pop on the same edge at DEPTH-1
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_cmd(OP_ADD, 1'b0, 4'(k), 4'd8, 1'b0);
      tick();
    end
    chk("t6_hold_s", 32'(res_s), 32'd8);
    set_cmd(OP_ADD, 1'b0, 4'd4, 4'd8, 1'b0);
    res_ready = 1'b1;
    chk("t6_pre_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("t6_post_ready", 32'(cmd_ready), 32'd1);
    chk("t6_post_valid", 32'(res_valid), 32'd0);
    for (int k = 1; k < 5; k++) begin
      tick();
      chk($sformatf("t6_r%0d_valid", k), 32'(res_valid), 32'd1);
      chk($sformatf("t6_r%0d_s", k),     32'(res_s),     32'(k + 8));
      tick();
    end
    chk("t6_done_valid", 32'(res_valid), 32'd0);
    chk("t6_done_busy",  32'(busy),      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
